// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : mmio_uart_tx
//  Purpose  : Memory-mapped 8N1 UART transmitter with a byte TX FIFO.
//             TXDATA (BASE+0) pushes a byte, STATUS (BASE+4) reports
//             full/busy/empty/overflow/count and clears overflow (W1C).
//  Revision : 1.0 - initial release
// ============================================================================
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  memWMask,
  input  logic [31:0] addr,
  input  logic [31:0] memWdata,
  output logic [31:0] memRdata,
  output logic        tx,
  output logic        busy
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [31:0]       STATUS_ADDR = BASE_ADDR + 32'd4;
  localparam logic [CNT_W-1:0]  DEPTH_CNT   = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W-1:0]  PTR_ONE     = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shifter;

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  logic full;
  logic empty;
  logic hit_tx;
  logic hit_status;
  logic wr_tx;
  logic push;
  logic drop;
  logic clr_ovf;
  logic bit_done;
  logic pop;

  // Only the low data byte and mask bit 0 carry meaning on this bus.
  logic unused_bits;
  assign unused_bits = ^{memWMask[3:1], memWdata[31:8]};

  assign full       = (count == DEPTH_CNT);
  assign empty      = (count == '0);
  assign hit_tx     = (addr == BASE_ADDR);
  assign hit_status = (addr == STATUS_ADDR);
  assign wr_tx      = hit_tx & memWMask[0];
  // Fullness is judged on the pre-edge count, so a same-cycle pop does not
  // rescue a store that arrives while the FIFO is full.
  assign push       = wr_tx & ~full;
  assign drop       = wr_tx & full;
  assign clr_ovf    = hit_status & memWMask[0] & memWdata[3];
  assign bit_done   = (baud_cnt == BAUD_LAST);
  // The FSM takes the head byte from IDLE, or at the end of STOP so that
  // back-to-back frames have no idle gap.
  assign pop        = ~empty & ((state == IDLE) | ((state == STOP) & bit_done));
  assign busy       = (state != IDLE) | ~empty;

  // FIFO storage: written only on an accepted push, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= memWdata[7:0];
    end
  end

  // FIFO pointers, occupancy count and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
      // A new overflow outranks a clear arriving on the same edge.
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  // Transmit FSM: baud timing, bit serialisation and the registered line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shifter  <= 8'd0;
      tx       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          tx       <= 1'b1;
          if (!empty) begin
            state   <= START;
            shifter <= fifo_mem[rd_ptr];
            tx      <= 1'b0;
          end
        end
        START: begin
          if (bit_done) begin
            state    <= DATA;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            tx       <= shifter[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              shifter <= shifter >> 1;
              tx      <= shifter[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (!empty) begin
              state   <= START;
              shifter <= fifo_mem[rd_ptr];
              tx      <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          tx       <= 1'b1;
        end
      endcase
    end
  end

  // Combinational read mux; TXDATA and undecoded addresses read as zero.
  always_comb begin
    memRdata = 32'h0;
    if (hit_status) begin
      memRdata = {16'h0, 8'(count), 4'h0, overflow, empty, busy, full};
    end
  end

endmodule
`default_nettype wire
